// File: rtl/mode_controller_if.sv
// Signal bundle between the board/engines and the keyboard mode controller.
interface mode_controller_if #(
   parameter int unsigned NUM_KEYS = 7,
   parameter int unsigned NOTE_W   = 4
);
   // Board inputs
   logic [NUM_KEYS-1:0] keys;
   logic [2:0]          mode;
   logic [1:0]          octave_sel;
   // Auto-play engine
   logic [NOTE_W-1:0]   note_auto;
   logic [NUM_KEYS-1:0] led_auto;
   logic [1:0]          octave_auto;
   // Learn engine
   logic [NOTE_W-1:0]   note_learn;
   logic [NUM_KEYS-1:0] led_learn;
   // Controller outputs
   logic                auto_en;
   logic                learn_en;
   logic [NOTE_W-1:0]   note_out;
   logic [NUM_KEYS-1:0] led_out;
   logic [1:0]          octave_out;
   logic [2:0]          mode_active;
   logic                mode_err;

   // Board / engine side
   modport master (
      output keys, mode, octave_sel,
      output note_auto, led_auto, octave_auto,
      output note_learn, led_learn,
      input  auto_en, learn_en, note_out, led_out, octave_out,
      input  mode_active, mode_err
   );

   // Controller side
   modport slave (
      input  keys, mode, octave_sel,
      input  note_auto, led_auto, octave_auto,
      input  note_learn, led_learn,
      output auto_en, learn_en, note_out, led_out, octave_out,
      output mode_active, mode_err
   );
endinterface

// File: rtl/mode_controller.sv
// Keyboard mode controller: debounced mode switches, mode FSM with a silent
// changeover gap, and output muxing between free play, auto and learn engines.
module mode_controller #(
   parameter int unsigned NUM_KEYS    = 7,
   parameter int unsigned NOTE_W      = 4,
   parameter int unsigned MODE_STABLE = 16,
   parameter int unsigned MUTE_CYCLES = 8
) (
   input logic              clk,
   input logic              reset,
   mode_controller_if.slave bus
);

   localparam int unsigned CNT_W  = (MODE_STABLE > 1) ? $clog2(MODE_STABLE) : 1;
   localparam int unsigned MUTE_W = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MODE_STABLE - 1);
   localparam logic [MUTE_W-1:0] MUTE_LOAD = MUTE_W'(MUTE_CYCLES - 1);

   localparam logic [2:0] MODE_FREE  = 3'b100;
   localparam logic [2:0] MODE_AUTO  = 3'b010;
   localparam logic [2:0] MODE_LEARN = 3'b001;
   localparam logic [1:0] OCT_DEFAULT = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUTE,
      ST_FREE,
      ST_AUTO,
      ST_LEARN
   } state_t;

   // Mode filter
   logic [2:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       acc_q, acc_d;
   logic             accept_q, accept_d;
   logic             acc_valid;

   // Mode FSM
   state_t            state_q, state_d;
   state_t            target_q, target_d;
   state_t            acc_state;
   logic [MUTE_W-1:0] mute_q, mute_d;
   logic              err_q, err_d;

   // Free-play key path and registered outputs
   logic [NUM_KEYS-1:0] key_q;
   logic [NOTE_W-1:0]   free_note;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [NUM_KEYS-1:0] led_q, led_d;
   logic [1:0]          oct_q, oct_d;
   logic [2:0]          act_q, act_d;
   logic                aen_q, aen_d;
   logic                len_q, len_d;

   // Filter next state: restart on any change, accept once a held value has aged
   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      accept_d = 1'b0;
      if (bus.mode != cand_q) begin
         cand_d = bus.mode;
         cnt_d  = '0;
      end else if (cnt_q != CNT_LAST) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if ((cnt_q == CNT_LAST) && (cand_q != acc_q)) begin
         accept_d = 1'b1;
         acc_d    = cand_q;
      end
   end

   // Filter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand_q   <= 3'b000;
         cnt_q    <= '0;
         acc_q    <= 3'b000;
         accept_q <= 1'b0;
      end else begin
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         accept_q <= accept_d;
      end
   end

   // Decode the accepted value into a target state and a validity flag
   always_comb begin
      acc_valid = 1'b1;
      acc_state = ST_IDLE;
      case (acc_q)
         MODE_FREE:  acc_state = ST_FREE;
         MODE_AUTO:  acc_state = ST_AUTO;
         MODE_LEARN: acc_state = ST_LEARN;
         default:    acc_valid = 1'b0;
      endcase
   end

   // Mode FSM next state: every valid change passes through MUTE, bad values park in IDLE
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      mute_d   = mute_q;
      err_d    = err_q;
      if (accept_q) begin
         if (acc_valid) begin
            state_d  = ST_MUTE;
            target_d = acc_state;
            mute_d   = MUTE_LOAD;
            err_d    = 1'b0;
         end else begin
            state_d = ST_IDLE;
            mute_d  = '0;
            err_d   = 1'b1;
         end
      end else if (state_q == ST_MUTE) begin
         if (mute_q == '0) begin
            state_d = target_q;
         end else begin
            mute_d = mute_q - MUTE_W'(1);
         end
      end
   end

   // Mode FSM registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         target_q <= ST_IDLE;
         mute_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         mute_q   <= mute_d;
         err_q    <= err_d;
      end
   end

   // Key switch capture for free play
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_q <= '0;
      end else begin
         key_q <= bus.keys;
      end
   end

   // Lowest pressed key wins; note codes are key index + 1, 0 means silence
   always_comb begin
      free_note = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (key_q[i]) begin
            free_note = NOTE_W'(i + 1);
         end
      end
   end

   // Output select follows the next state so outputs and state switch on the same edge
   always_comb begin
      note_d = '0;
      led_d  = '0;
      oct_d  = OCT_DEFAULT;
      act_d  = 3'b000;
      aen_d  = 1'b0;
      len_d  = 1'b0;
      case (state_d)
         ST_FREE: begin
            note_d = free_note;
            led_d  = key_q;
            oct_d  = bus.octave_sel;
            act_d  = MODE_FREE;
         end
         ST_AUTO: begin
            note_d = bus.note_auto;
            led_d  = bus.led_auto;
            oct_d  = bus.octave_auto;
            act_d  = MODE_AUTO;
            aen_d  = 1'b1;
         end
         ST_LEARN: begin
            note_d = bus.note_learn;
            led_d  = bus.led_learn;
            act_d  = MODE_LEARN;
            len_d  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         note_q <= '0;
         led_q  <= '0;
         oct_q  <= OCT_DEFAULT;
         act_q  <= 3'b000;
         aen_q  <= 1'b0;
         len_q  <= 1'b0;
      end else begin
         note_q <= note_d;
         led_q  <= led_d;
         oct_q  <= oct_d;
         act_q  <= act_d;
         aen_q  <= aen_d;
         len_q  <= len_d;
      end
   end

   assign bus.note_out    = note_q;
   assign bus.led_out     = led_q;
   assign bus.octave_out  = oct_q;
   assign bus.mode_active = act_q;
   assign bus.auto_en     = aen_q;
   assign bus.learn_en    = len_q;
   assign bus.mode_err    = err_q;

endmodule
